// File: rtl/mux_out_deglitch.sv
// Two-flop synchronizer plus stability filter for the raw mux output; filt_out commits STABLE_CYCLES+1 edges after the first edge that samples a new level.
// No backpressure: strobes are single-cycle, and glitch_cnt saturates instead of wrapping.
module mux_out_deglitch #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mux_out,
  input  logic             clear_cnt,
  output logic             filt_out,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state_q, state_d;
  logic       sync0, sync1;
  logic [7:0] run_cnt, run_cnt_d;
  logic       commit, reject;

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync1 != filt_out) begin
          if (STABLE_LIM == 8'd1) begin
            commit = 1'b1;
          end else begin
            run_cnt_d = 8'd1;
            state_d   = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // A reversion on the would-be commit edge is still a glitch.
        if (sync1 == filt_out) begin
          reject    = 1'b1;
          run_cnt_d = 8'd0;
          state_d   = ST_STABLE;
        end else if (run_cnt + 8'd1 == STABLE_LIM) begin
          commit  = 1'b1;
          state_d = ST_STABLE;
        end else begin
          run_cnt_d = run_cnt + 8'd1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
    if (commit) begin
      run_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      state_q    <= ST_STABLE;
      run_cnt    <= 8'd0;
      filt_out   <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync0   <= mux_out;
      sync1   <= sync0;
      state_q <= state_d;
      run_cnt <= run_cnt_d;
      rise    <= commit & sync1;
      fall    <= commit & ~sync1;
      glitch  <= reject;
      if (commit) begin
        filt_out <= sync1;
      end
      if (clear_cnt) begin
        glitch_cnt <= '0;
      end else if (reject && (glitch_cnt != CNT_MAX)) begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_out_deglitch.sv
// Directed and random checks of two deglitcher instances (STABLE_CYCLES=4/CNT_W=2 and STABLE_CYCLES=1/CNT_W=8)
// against a run-length reference model of the sampled input.
module tb_mux_out_deglitch;

  logic       clk = 1'b0;
  logic       rst;
  logic       mux_a, clr_a, mux_b, clr_b;
  logic       filt_a, rise_a, fall_a, glitch_a;
  logic       filt_b, rise_b, fall_b, glitch_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  int gl_seen_a = 0;

  // Reference model state per instance: index 0 = a, 1 = b.
  int m_s0[2], m_s1[2], m_filt[2], m_run[2];
  int m_rise[2], m_fall[2], m_gl[2], m_cnt[2];

  always #5 clk = ~clk;

  mux_out_deglitch #(.STABLE_CYCLES(4), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .mux_out(mux_a), .clear_cnt(clr_a),
    .filt_out(filt_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a), .glitch_cnt(cnt_a)
  );

  mux_out_deglitch #(.STABLE_CYCLES(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .mux_out(mux_b), .clear_cnt(clr_b),
    .filt_out(filt_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b), .glitch_cnt(cnt_b)
  );

  function automatic int sc_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 0) ? 3 : 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s0[d] = 0; m_s1[d] = 0; m_filt[d] = 0; m_run[d] = 0;
      m_rise[d] = 0; m_fall[d] = 0; m_gl[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // One sampling edge: count how long the synchronized level has disagreed with the
  // published level; accept once the run reaches STABLE_CYCLES, reject if it breaks early.
  task automatic model_edge(input int d, input logic mux, input logic clr);
    bit ev_commit = 0;
    bit ev_rej    = 0;
    if (m_s1[d] != m_filt[d]) begin
      m_run[d]++;
      if (m_run[d] >= sc_of(d)) ev_commit = 1;
    end else if (m_run[d] > 0) begin
      ev_rej = 1;
    end
    m_rise[d] = (ev_commit && m_s1[d] == 1) ? 1 : 0;
    m_fall[d] = (ev_commit && m_s1[d] == 0) ? 1 : 0;
    m_gl[d]   = ev_rej ? 1 : 0;
    if (ev_commit) begin
      m_filt[d] = m_s1[d];
      m_run[d]  = 0;
    end
    if (ev_rej) m_run[d] = 0;
    if (clr) m_cnt[d] = 0;
    else if (ev_rej && m_cnt[d] < cmax_of(d)) m_cnt[d]++;
    m_s1[d] = m_s0[d];
    m_s0[d] = int'(mux);
  endtask

  task automatic check_all();
    chk("a_filt",   filt_a,   m_filt[0]);
    chk("a_rise",   rise_a,   m_rise[0]);
    chk("a_fall",   fall_a,   m_fall[0]);
    chk("a_glitch", glitch_a, m_gl[0]);
    chk("a_cnt",    cnt_a,    m_cnt[0]);
    chk("b_filt",   filt_b,   m_filt[1]);
    chk("b_rise",   rise_b,   m_rise[1]);
    chk("b_fall",   fall_b,   m_fall[1]);
    chk("b_glitch", glitch_b, m_gl[1]);
    chk("b_cnt",    cnt_b,    m_cnt[1]);
    chk("a_excl", (int'(rise_a) + int'(fall_a) + int'(glitch_a)) <= 1, 1);
    chk("b_excl", (int'(rise_b) + int'(fall_b) + int'(glitch_b)) <= 1, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, mux_a, clr_a);
      model_edge(1, mux_b, clr_b);
    end
    #1;
    check_all();
    if (glitch_a) gl_seen_a++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_start;
    int last_rise_b;
    logic hist_b[32];
    int hold_a, hold_b;

    rst = 1'b1; mux_a = 1'b0; clr_a = 1'b0; mux_b = 1'b0; clr_b = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_filt_a", filt_a, 0);
    chk("reset_cnt_a",  cnt_a,  0);
    rst = 1'b0;

    // Held-high level commits on E5 with a single rise.
    mux_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) chk("held_pre_commit", filt_a, 0);
      if (i == 5) begin
        chk("held_commit_filt", filt_a, 1);
        chk("held_commit_rise", rise_a, 1);
      end
      if (i == 6) chk("held_rise_one_cycle", rise_a, 0);
    end
    chk("held_no_glitch_cnt", cnt_a, 0);

    // Single-sample excursion is rejected on E3.
    mux_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mux_a = 1'b1;
      if (i == 3) begin
        chk("single_glitch_pulse", glitch_a, 1);
        chk("single_glitch_cnt",   cnt_a,    1);
        chk("single_glitch_filt",  filt_a,   1);
      end
    end

    // Three edges: rejected on E5.
    for (int i = 0; i < 8; i++) begin
      mux_a = (i < 3) ? 1'b0 : 1'b1;
      tick();
      if (i == 5) begin
        chk("len3_glitch", glitch_a, 1);
        chk("len3_cnt",    cnt_a,    2);
      end
    end

    // Four edges: commit on E5 with fall.
    mux_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) chk("len4_pre_commit", filt_a, 1);
      if (i == 5) begin
        chk("len4_commit_filt", filt_a,   0);
        chk("len4_commit_fall", fall_a,   1);
        chk("len4_no_glitch",   glitch_a, 0);
      end
    end

    // Saturation at 3 with CNT_W=2, then clear colliding with a glitch.
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    g_start = gl_seen_a;
    for (int g = 0; g < 5; g++) begin
      mux_a = 1'b1;
      tick();
      mux_a = 1'b0;
      for (int i = 0; i < 4; i++) tick();
    end
    chk("sat_cnt",        cnt_a,               3);
    chk("sat_pulse_count", gl_seen_a - g_start, 5);
    mux_a = 1'b1;
    tick();
    mux_a = 1'b0;
    tick();
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clear_vs_glitch_pulse", glitch_a, 1);
    chk("clear_vs_glitch_cnt",   cnt_a,    0);
    tick();

    // Pulse confined to the low clock phase is never sampled.
    g_start = gl_seen_a;
    @(negedge clk);
    mux_a = 1'b1;
    #2 mux_a = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("subcycle_no_glitch", gl_seen_a - g_start, 0);
    chk("subcycle_filt",      filt_a,              0);

    // Reset arriving while a change is pending in CHECK.
    mux_a = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_filt",   filt_a,   0);
    chk("rst_async_rise",   rise_a,   0);
    chk("rst_async_fall",   fall_a,   0);
    chk("rst_async_glitch", glitch_a, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) chk("post_rst_pre_commit", filt_a, 0);
      if (i == 5) begin
        chk("post_rst_commit", filt_a, 1);
        chk("post_rst_rise",   rise_a, 1);
      end
    end

    // STABLE_CYCLES=1: toggle every two cycles; output trails the sample by two edges.
    last_rise_b = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) mux_b = ~mux_b;
      hist_b[i] = mux_b;
      tick();
      if (i >= 2) chk("b_follow", filt_b, hist_b[i-2]);
      chk("b_toggle_no_glitch", glitch_b, 0);
      if (rise_b) begin
        chk("b_alternate_rise", last_rise_b, 0);
        last_rise_b = 1;
      end
      if (fall_b) begin
        chk("b_alternate_fall", last_rise_b, 1);
        last_rise_b = 0;
      end
    end

    // Random runs of assorted lengths on both instances.
    hold_a = 0;
    hold_b = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_a == 0) begin
        mux_a  = ~mux_a;
        hold_a = $urandom_range(1, 6);
      end
      if (hold_b == 0) begin
        mux_b  = ~mux_b;
        hold_b = $urandom_range(1, 3);
      end
      hold_a--;
      hold_b--;
      clr_a = ($urandom_range(0, 31) == 0);
      clr_b = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
